sr04_meas_sequencer: RTL and testbench

Measurement sequencer sitting between the ultrasonic ranging controller and the FND display path. It issues periodic one-cycle `start` pulses to the controller and watches the shared echo pin to detect when a measurement completes. It then captures the controller's 24-bit `distance`, clamps it, and applies a power-of-two moving average. The averaged centimetre value is converted to three BCD digits and presented with a one-cycle valid strobe.

---
 rtl/sr04_meas_sequencer.sv | 168 ++++++++++++++++
 tb/tb_sr04_meas_sequencer.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/sr04_meas_sequencer.sv
// sr04_meas_sequencer: periodic start pulses, echo completion detect, clamped moving average,
// double-dabble BCD conversion with one-cycle result strobe.
module sr04_meas_sequencer #(
   parameter int unsigned CLK_HZ     = 100_000_000,
   parameter int unsigned PERIOD_MS  = 100,
   parameter int unsigned TIMEOUT_MS = 30,
   parameter int unsigned AVG_LOG2   = 2,
   parameter int unsigned MAX_CM     = 400
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        echo,
   input  logic [23:0] distance,
   output logic        start,
   output logic [8:0]  dist_cm,
   output logic [11:0] dist_bcd,
   output logic        dist_valid,
   output logic        timeout,
   output logic        busy
);
   localparam int unsigned PERIOD_CYC  = CLK_HZ / 1000 * PERIOD_MS;
   localparam int unsigned TIMEOUT_CYC = CLK_HZ / 1000 * TIMEOUT_MS;
   localparam int PW = $clog2(PERIOD_CYC);
   localparam int TW = $clog2(TIMEOUT_CYC);
   localparam int CW = (TW > 4) ? TW : 4;
   localparam int N  = 1 << AVG_LOG2;
   localparam int SW = 9 + AVG_LOG2;

   typedef enum logic [2:0] {IDLE, WAIT_RISE, WAIT_FALL, SETTLE, SAMPLE, BCD, OUT} state_t;

   state_t        state_q, state_d;
   logic [2:0]    echo_q;
   logic          rise_q, fall_q;
   logic [PW-1:0] per_q;
   logic          tick;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          first_q, first_d;
   logic [SW-1:0] sum_q, sum_d, new_sum;
   logic [AVG_LOG2-1:0] wp_q, wp_d;
   logic [8:0]    win_q [N];
   logic [8:0]    win_d [N];
   logic [8:0]    avg_q, avg_d, samp;
   logic [20:0]   dd_q, dd_d, adj;
   logic          start_q, start_d, timeout_q, timeout_d, valid_q, valid_d;
   logic [8:0]    dist_cm_q, dist_cm_d;
   logic [11:0]   dist_bcd_q, dist_bcd_d;

   assign tick       = enable && (per_q == PW'(PERIOD_CYC - 1));
   assign start      = start_q;
   assign timeout    = timeout_q;
   assign dist_valid = valid_q;
   assign dist_cm    = dist_cm_q;
   assign dist_bcd   = dist_bcd_q;
   assign busy       = state_q != IDLE;

   always_comb begin
      samp    = (distance > 24'(MAX_CM)) ? 9'(MAX_CM) : distance[8:0];
      new_sum = first_q ? SW'(samp) << AVG_LOG2 : sum_q + SW'(samp) - SW'(win_q[wp_q]);
      adj     = dd_q;
      for (int k = 0; k < 3; k++)
         adj[9+4*k +: 4] = (dd_q[9+4*k +: 4] >= 4'd5) ? dd_q[9+4*k +: 4] + 4'd3 : dd_q[9+4*k +: 4];
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      first_d    = first_q;
      sum_d      = sum_q;
      wp_d       = wp_q;
      win_d      = win_q;
      avg_d      = avg_q;
      dd_d       = dd_q;
      start_d    = 1'b0;
      timeout_d  = 1'b0;
      valid_d    = 1'b0;
      dist_cm_d  = dist_cm_q;
      dist_bcd_d = dist_bcd_q;
      case (state_q)
         IDLE: if (tick) begin
            start_d = 1'b1;
            cnt_d   = '0;
            state_d = WAIT_RISE;
         end
         WAIT_RISE, WAIT_FALL: begin
            cnt_d = cnt_q + 1'b1;
            // timeout has priority over an edge arriving on the same cycle
            if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
               timeout_d = 1'b1;
               state_d   = IDLE;
            end else if (state_q == WAIT_RISE && rise_q) begin
               state_d = WAIT_FALL;
            end else if (state_q == WAIT_FALL && fall_q) begin
               cnt_d   = '0;
               state_d = SETTLE;
            end
         end
         SETTLE: begin
            cnt_d   = (cnt_q == CW'(3)) ? '0 : cnt_q + 1'b1;
            state_d = (cnt_q == CW'(3)) ? SAMPLE : SETTLE;
         end
         SAMPLE: begin
            for (int i = 0; i < N; i++)
               if (first_q || AVG_LOG2'(i) == wp_q) win_d[i] = samp;
            wp_d    = first_q ? '0 : wp_q + 1'b1;
            first_d = 1'b0;
            sum_d   = new_sum;
            avg_d   = 9'(new_sum >> AVG_LOG2);
            dd_d    = {12'd0, 9'(new_sum >> AVG_LOG2)};
            cnt_d   = '0;
            state_d = BCD;
         end
         BCD: begin
            dd_d  = {adj[19:0], 1'b0};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(8)) begin
               cnt_d      = '0;
               valid_d    = 1'b1;
               dist_cm_d  = avg_q;
               dist_bcd_d = adj[19:8];
               state_d    = OUT;
            end
         end
         OUT:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         echo_q     <= '0;
         rise_q     <= 1'b0;
         fall_q     <= 1'b0;
         per_q      <= '0;
         cnt_q      <= '0;
         first_q    <= 1'b1;
         sum_q      <= '0;
         wp_q       <= '0;
         win_q      <= '{default: '0};
         avg_q      <= '0;
         dd_q       <= '0;
         start_q    <= 1'b0;
         timeout_q  <= 1'b0;
         valid_q    <= 1'b0;
         dist_cm_q  <= '0;
         dist_bcd_q <= '0;
      end else begin
         state_q    <= state_d;
         echo_q     <= {echo_q[1:0], echo};
         rise_q     <= echo_q[1] & ~echo_q[2];
         fall_q     <= ~echo_q[1] & echo_q[2];
         per_q      <= (!enable || per_q == PW'(PERIOD_CYC - 1)) ? '0 : per_q + 1'b1;
         cnt_q      <= cnt_d;
         first_q    <= first_d;
         sum_q      <= sum_d;
         wp_q       <= wp_d;
         win_q      <= win_d;
         avg_q      <= avg_d;
         dd_q       <= dd_d;
         start_q    <= start_d;
         timeout_q  <= timeout_d;
         valid_q    <= valid_d;
         dist_cm_q  <= dist_cm_d;
         dist_bcd_q <= dist_bcd_d;
      end
   end
endmodule

// File: tb/tb_sr04_meas_sequencer.sv
// tb_sr04_meas_sequencer: directed checks of period, timeout, averaging, clamp and reset behaviour.
module tb_sr04_meas_sequencer;
   logic        clk = 1'b0, rst = 1'b0, enable = 1'b0, echo = 1'b0;
   logic [23:0] distance = '0;
   logic        start, dist_valid, timeout, busy;
   logic [8:0]  dist_cm;
   logic [11:0] dist_bcd;
   int cyc = 0, n_checks = 0, n_errors = 0;
   int start_cnt = 0, start_cyc = 0, valid_cnt = 0, valid_cyc = 0, to_cnt = 0, to_cyc = 0, overlap = 0;
   logic busy_at_to = 1'b1;
   int e;

   sr04_meas_sequencer #(.CLK_HZ(1_000_000), .PERIOD_MS(2), .TIMEOUT_MS(1), .AVG_LOG2(2), .MAX_CM(400)) dut (
      .clk(clk), .rst(rst), .enable(enable), .echo(echo), .distance(distance),
      .start(start), .dist_cm(dist_cm), .dist_bcd(dist_bcd), .dist_valid(dist_valid),
      .timeout(timeout), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (start) begin start_cnt <= start_cnt + 1; start_cyc <= cyc; end
      if (dist_valid) begin valid_cnt <= valid_cnt + 1; valid_cyc <= cyc; end
      if (timeout) begin to_cnt <= to_cnt + 1; to_cyc <= cyc; busy_at_to <= busy; end
      if (dist_valid && timeout) overlap <= overlap + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic wait_new_start(input string tag);
      int s0 = start_cnt;
      for (int k = 0; k < 2200 && start_cnt == s0; k++) step();
      check({tag, "_start_seen"}, 32'(start_cnt != s0), 1);
   endtask

   task automatic wait_timeout(input string tag);
      int t0 = to_cnt;
      for (int k = 0; k < 1100 && to_cnt == t0; k++) step();
      check({tag, "_timeout_seen"}, 32'(to_cnt != t0), 1);
   endtask

   task automatic measure(input logic [23:0] d, input logic [31:0] exp_cm, input logic [31:0] exp_bcd, input string tag);
      int p, v0;
      wait_new_start(tag);
      step(10);
      echo = 1'b1;
      step(200);
      distance = d;
      step();
      echo = 1'b0;
      p = cyc;
      v0 = valid_cnt;
      for (int k = 0; k < 40 && valid_cnt == v0; k++) step();
      check({tag, "_valid_seen"}, valid_cnt - v0, 1);
      check({tag, "_latency"}, valid_cyc - p, 18);
      check({tag, "_cm"}, dist_cm, exp_cm);
      check({tag, "_bcd"}, dist_bcd, exp_bcd);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      step(2);
      rst = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 20; i++) begin
         step();
         echo = ~echo;
         enable = ~enable;
      end
      check("rst_start", start, 0);
      check("rst_cm", dist_cm, 0);
      check("rst_bcd", dist_bcd, 0);
      check("rst_valid", dist_valid, 0);
      check("rst_timeout", timeout, 0);
      check("rst_busy", busy, 0);
      check("rst_no_start", start_cnt, 0);
      echo = 1'b0;
      enable = 1'b0;
      step();
      rst = 1'b1;
      step(3);
      enable = 1'b1;
      e = cyc;
      wait_new_start("p1");
      check("p1_lat", start_cyc - e, 2000);
      wait_timeout("to1");
      check("to1_lat", to_cyc - start_cyc, 1000);
      check("to1_busy", busy_at_to, 0);
      check("to1_no_valid", valid_cnt, 0);
      wait_new_start("p2");
      check("p2_lat", start_cyc - e, 4000);
      measure(24'd150, 150, 'h150, "m150");
      do_reset();
      measure(24'd100, 100, 'h100, "avg1");
      measure(24'd200, 125, 'h125, "avg2");
      measure(24'd100, 125, 'h125, "avg3");
      measure(24'd200, 150, 'h150, "avg4");
      do_reset();
      measure(24'd1000, 400, 'h400, "clamp");
      begin
         int v0;
         wait_new_start("to2");
         v0 = valid_cnt;
         wait_timeout("to2");
         check("to2_lat", to_cyc - start_cyc, 1000);
         step(5);
         check("to2_busy", busy, 0);
         check("to2_no_valid", valid_cnt - v0, 0);
         check("to2_cm_kept", dist_cm, 400);
      end
      wait_new_start("mid");
      step(10);
      echo = 1'b1;
      step(50);
      check("mid_busy_before", busy, 1);
      rst = 1'b0;
      #1;
      check("mid_cm", dist_cm, 0);
      check("mid_bcd", dist_bcd, 0);
      check("mid_busy", busy, 0);
      check("mid_valid", dist_valid, 0);
      echo = 1'b0;
      step(2);
      rst = 1'b1;
      measure(24'd80, 80, 'h080, "refill");
      check("no_overlap", overlap, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
